// File: rtl/rams_sdp_acc_3d.sv
// rams_sdp_acc_3d
//   Multi-bank simple dual-port RAM used as an integration store. Each bank
//   has a two-stage write port (overwrite or accumulate), a read port with
//   1 or 2 cycles of latency, and all banks share one clear sequencer that
//   zeroes the whole array between integration frames.
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset (control, read pipe, in-flight writes)
//   wea    in   [NUM_RAMS]            port A write request per bank
//   mode   in   [NUM_RAMS]            0 = overwrite, 1 = accumulate
//   addra  in   [NUM_RAMS][A_WID]     port A address per bank
//   dina   in   [NUM_RAMS][D_WID]     port A data per bank
//   enb    in   [NUM_RAMS]            port B read request per bank
//   addrb  in   [NUM_RAMS][A_WID]     port B address per bank
//   doutb  out  [NUM_RAMS][D_WID]     read data, holds between reads
//   vldb   out  [NUM_RAMS]            one pulse per completed read
//   clr    in   request to zero every bank
//   busy   out  clear sweep in progress
module rams_sdp_acc_3d #(
  parameter int NUM_RAMS = 2,
  parameter int A_WID    = 10,
  parameter int D_WID    = 32,
  parameter int RD_LAT   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RAMS-1:0]              wea,
  input  logic [NUM_RAMS-1:0]              mode,
  input  logic [NUM_RAMS-1:0][A_WID-1:0]   addra,
  input  logic [NUM_RAMS-1:0][D_WID-1:0]   dina,
  input  logic [NUM_RAMS-1:0]              enb,
  input  logic [NUM_RAMS-1:0][A_WID-1:0]   addrb,
  output logic [NUM_RAMS-1:0][D_WID-1:0]   doutb,
  output logic [NUM_RAMS-1:0]              vldb,
  input  logic                             clr,
  output logic                             busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Accumulation wraps modulo 2**D_WID.
  function automatic logic [D_WID-1:0] acc_wrap(input logic [D_WID-1:0] a,
                                                input logic [D_WID-1:0] b);
    return a + b;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [A_WID-1:0] swp_addr_q, swp_addr_d;
  logic             clr_acc;

  assign busy    = (state_q == ST_SWEEP);
  // Only an idle sequencer takes a clear; a clear during a sweep is ignored.
  assign clr_acc = (state_q == ST_IDLE) && clr;

  always_comb begin
    state_d    = state_q;
    swp_addr_d = swp_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d    = ST_SWEEP;
          swp_addr_d = '0;
        end
      end
      default: begin
        swp_addr_d = swp_addr_q + 1'b1;
        if (swp_addr_q == '1) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      swp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      swp_addr_q <= swp_addr_d;
    end
  end

  for (genvar g = 0; g < NUM_RAMS; g++) begin : g_bank
    logic [D_WID-1:0] mem [2**A_WID];

    logic             a_vld_p0;
    logic             a_mode_p0;
    logic [A_WID-1:0] a_addr_p0;
    logic [D_WID-1:0] a_din_p0;
    logic             a_take;
    logic             a_commit;
    logic [D_WID-1:0] a_wdata;

    // ---- A1: capture request (blocked while sweeping or on clear acceptance)
    assign a_take = wea[g] && !busy && !clr_acc;

    always_ff @(posedge clk) begin
      if (rst) a_vld_p0 <= 1'b0;
      else     a_vld_p0 <= a_take;
    end

    always_ff @(posedge clk) begin
      if (a_take) begin
        a_mode_p0 <= mode[g];
        a_addr_p0 <= addra[g];
        a_din_p0  <= dina[g];
      end
    end

    // ---- A2: read-modify-write commit. The array is read in the same cycle
    // the result is written, so every earlier request to this address has
    // already landed and back-to-back accumulates chain without a stall.
    assign a_commit = a_vld_p0 && !clr_acc;
    assign a_wdata  = a_mode_p0 ? acc_wrap(mem[a_addr_p0], a_din_p0) : a_din_p0;

    always_ff @(posedge clk) begin
      if (!rst) begin
        if (state_q == ST_SWEEP) mem[swp_addr_q] <= '0;
        else if (a_commit)       mem[a_addr_p0]  <= a_wdata;
      end
    end

    // ---- B0: registered memory read
    logic             rd_vld_p0;
    logic [D_WID-1:0] rd_data_p0;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_vld_p0  <= 1'b0;
        rd_data_p0 <= '0;
      end else begin
        rd_vld_p0 <= enb[g];
        if (enb[g]) rd_data_p0 <= mem[addrb[g]];
      end
    end

    if (RD_LAT == 1) begin : g_lat1
      assign doutb[g] = rd_data_p0;
      assign vldb[g]  = rd_vld_p0;
    end else begin : g_lat2
      // ---- B1: extra output register (any value other than 1 means 2)
      logic             rd_vld_p1;
      logic [D_WID-1:0] rd_data_p1;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_vld_p1  <= 1'b0;
          rd_data_p1 <= '0;
        end else begin
          rd_vld_p1 <= rd_vld_p0;
          if (rd_vld_p0) rd_data_p1 <= rd_data_p0;
        end
      end

      assign doutb[g] = rd_data_p1;
      assign vldb[g]  = rd_vld_p1;
    end
  end

endmodule

// File: tb/tb_rams_sdp_acc_3d.sv
module tb_rams_sdp_acc_3d;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 8;

  logic                 clk;
  logic                 rst;
  logic [NR-1:0]        wea, mode, enb;
  logic [NR-1:0][AW-1:0] addra, addrb;
  logic [NR-1:0][DW-1:0] dina;
  logic                 clr;
  logic [NR-1:0][DW-1:0] doutb1, doutb2;
  logic [NR-1:0]        vldb1, vldb2;
  logic                 busy1, busy2;

  int nvec  = 0;
  int nfail = 0;

  rams_sdp_acc_3d #(.NUM_RAMS(NR), .A_WID(AW), .D_WID(DW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .wea(wea), .mode(mode), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb1), .vldb(vldb1), .clr(clr), .busy(busy1)
  );

  rams_sdp_acc_3d #(.NUM_RAMS(NR), .A_WID(AW), .D_WID(DW), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .wea(wea), .mode(mode), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb2), .vldb(vldb2), .clr(clr), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int b, input bit acc, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wea[b] = 1'b1; mode[b] = acc; addra[b] = a; dina[b] = d;
  endtask

  // Read issued now; checks latency-1 copy next cycle and latency-2 copy the cycle after.
  task automatic rd_check(input int b, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input string nm);
    enb[b] = 1'b1; addrb[b] = a;
    tick();
    enb[b] = 1'b0;
    chk($sformatf("%s lat1 vld", nm), vldb1[b], 1);
    chk($sformatf("%s lat1 data", nm), doutb1[b], exp);
    chk($sformatf("%s lat2 early vld", nm), vldb2[b], 0);
    tick();
    chk($sformatf("%s lat2 vld", nm), vldb2[b], 1);
    chk($sformatf("%s lat2 data", nm), doutb2[b], exp);
    chk($sformatf("%s lat1 single pulse", nm), vldb1[b], 0);
  endtask

  task automatic do_clear();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      tick();
      n++;
    end
    chk("clear terminates lat1", busy1, 0);
    chk("clear terminates lat2", busy2, 0);
  endtask

  typedef struct {
    int              bank;
    bit              acc;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
    logic [DW-1:0]   exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cnt;

    vecs[0] = '{0, 1'b0, 4'd3,  8'h11, 8'h11};
    vecs[1] = '{1, 1'b0, 4'd3,  8'h22, 8'h22};
    vecs[2] = '{0, 1'b1, 4'd3,  8'h05, 8'h16};
    vecs[3] = '{1, 1'b1, 4'd3,  8'hF0, 8'h12};
    vecs[4] = '{0, 1'b0, 4'd9,  8'hF0, 8'hF0};
    vecs[5] = '{0, 1'b1, 4'd9,  8'h20, 8'h10};
    vecs[6] = '{1, 1'b1, 4'd12, 8'h7F, 8'h7F};
    vecs[7] = '{1, 1'b0, 4'd12, 8'h01, 8'h01};
    vecs[8] = '{0, 1'b1, 4'd0,  8'hFF, 8'hFF};
    vecs[9] = '{0, 1'b1, 4'd0,  8'h01, 8'h00};

    rst = 1'b1; clr = 1'b0;
    wea = '0; mode = '0; enb = '0;
    addra = '0; addrb = '0; dina = '0;
    tick(); tick();
    chk("reset busy lat1", busy1, 0);
    chk("reset busy lat2", busy2, 0);
    chk("reset vldb lat1", vldb1, 0);
    chk("reset vldb lat2", vldb2, 0);
    chk("reset doutb lat1", doutb1, 0);
    chk("reset doutb lat2", doutb2, 0);
    rst = 1'b0;
    tick();

    do_clear();

    // Table: single write/accumulate, readback issued two cycles later.
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].bank, vecs[i].acc, vecs[i].addr, vecs[i].din);
      tick();
      wea = '0;
      tick();
      rd_check(vecs[i].bank, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Both banks written in the same cycle, both read in t+2.
    wr(0, 1'b0, 4'd14, 8'h11);
    wr(1, 1'b0, 4'd14, 8'h22);
    tick();
    wea = '0;
    tick();
    enb = 2'b11; addrb[0] = 4'd14; addrb[1] = 4'd14;
    tick();
    enb = '0;
    chk("dual lat1 vld", vldb1, 2'b11);
    chk("dual lat1 b0", doutb1[0], 8'h11);
    chk("dual lat1 b1", doutb1[1], 8'h22);
    tick();
    chk("dual lat2 vld", vldb2, 2'b11);
    chk("dual lat2 b0", doutb2[0], 8'h11);
    chk("dual lat2 b1", doutb2[1], 8'h22);

    // Back-to-back accumulate 1+2+3+4 into a cleared location.
    for (int i = 1; i <= 4; i++) begin
      wr(0, 1'b1, 4'd5, 8'(i));
      tick();
    end
    wea = '0;
    tick();
    rd_check(0, 4'd5, 8'd10, "acc b2b");

    // Same with one idle cycle between requests.
    for (int i = 1; i <= 4; i++) begin
      wr(0, 1'b1, 4'd6, 8'(i));
      tick();
      wea = '0;
      tick();
    end
    rd_check(0, 4'd6, 8'd10, "acc gap");

    // Overwrite immediately followed by an accumulate.
    wr(0, 1'b0, 4'd5, 8'h40);
    tick();
    wr(0, 1'b1, 4'd5, 8'h01);
    tick();
    wea = '0;
    tick();
    rd_check(0, 4'd5, 8'h41, "ovw then acc");

    // Collision: reads in t and t+1 see old data, t+2 sees the new write.
    wr(0, 1'b0, 4'd7, 8'h0A);
    tick();
    wea = '0;
    tick(); tick();
    wr(0, 1'b0, 4'd7, 8'h0B);
    enb[0] = 1'b1; addrb[0] = 4'd7;
    tick();
    wea = '0;
    chk("coll rd t lat1", doutb1[0], 8'h0A);
    tick();
    chk("coll rd t+1 lat1", doutb1[0], 8'h0A);
    chk("coll rd t lat2", doutb2[0], 8'h0A);
    tick();
    enb = '0;
    chk("coll rd t+2 lat1", doutb1[0], 8'h0B);
    chk("coll rd t+1 lat2", doutb2[0], 8'h0A);
    tick();
    chk("coll rd t+2 lat2", doutb2[0], 8'h0B);
    chk("coll lat1 vld ends", vldb1[0], 0);

    // Clear: fill everything, clear with a concurrent write, poke during busy.
    for (int i = 0; i < 16; i++) begin
      wr(0, 1'b0, 4'(i), 8'(i + 1));
      wr(1, 1'b0, 4'(i), 8'(i + 8'h81));
      tick();
    end
    wea = '0;
    tick(); tick();
    clr = 1'b1;
    wr(0, 1'b0, 4'd2, 8'h55);
    tick();
    clr = 1'b0; wea = '0;
    chk("clear busy starts", busy1, 1);
    cnt = 0;
    while (busy1 && cnt < 40) begin
      cnt++;
      wea = '0; clr = 1'b0;
      if (cnt == 5) wr(0, 1'b0, 4'd0, 8'h77);
      if (cnt == 8) clr = 1'b1;
      tick();
    end
    wea = '0; clr = 1'b0;
    chk("clear busy cycles", 32'(cnt), 16);
    chk("clear busy lat2 dropped", busy2, 0);
    // First cycle after busy: port A accepted again.
    wr(1, 1'b0, 4'd9, 8'h33);
    tick();
    wea = '0;
    tick();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 2; b++) begin
        rd_check(b, 4'(a), (b == 1 && a == 9) ? 8'h33 : 8'h00,
                 $sformatf("clr b%0d a%0d", b, a));
      end
    end

    // Reset during an accumulate burst.
    wr(0, 1'b0, 4'd8, 8'h10);
    tick();
    wea = '0;
    tick(); tick();
    wr(0, 1'b1, 4'd8, 8'h01);
    tick();
    dina[0] = 8'h02;
    enb[0] = 1'b1; addrb[0] = 4'd8;
    tick();
    dina[0] = 8'h04;
    rst = 1'b1;
    tick();
    rst = 1'b0; wea = '0; enb = '0;
    chk("rst acc busy", busy1, 0);
    chk("rst acc vld lat1", vldb1, 0);
    chk("rst acc vld lat2", vldb2, 0);
    chk("rst acc dout lat1", doutb1, 0);
    chk("rst acc dout lat2", doutb2, 0);
    tick();
    rd_check(0, 4'd8, 8'h11, "rst acc mem");

    // Reset three cycles into a sweep (clr held too: reset wins).
    for (int i = 0; i < 6; i++) begin
      wr(0, 1'b0, 4'(i), 8'(8'hC0 + i));
      tick();
    end
    wea = '0;
    tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    enb[0] = 1'b1; addrb[0] = 4'd5;
    tick();
    enb = '0;
    chk("sweep read lat1", doutb1[0], 8'hC5);
    tick();
    rst = 1'b1; clr = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0;
    chk("rst sweep busy lat1", busy1, 0);
    chk("rst sweep busy lat2", busy2, 0);
    chk("rst sweep dout lat1", doutb1[0], 0);
    chk("rst sweep dout lat2", doutb2[0], 0);
    chk("rst sweep vld lat2", vldb2, 0);
    tick();
    for (int a = 0; a < 6; a++) begin
      rd_check(0, 4'(a), (a < 3) ? 8'h00 : 8'(8'hC0 + a), $sformatf("rst sweep a%0d", a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
